ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, is the RAM word size in bits.
REQ-002 Parameter ENTRIES, default 8, is the RAM depth (any value >= 2; need not be a power of two); AW = $clog2(ENTRIES).
REQ-003 Port clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_addr, input, AW: start address of a burst.
REQ-006 Port cmd_len, input, AW+1: burst length in words, 0..ENTRIES.
REQ-007 Port cmd_valid, input, 1: a command is present.
REQ-008 Port cmd_ready, output, 1: the block accepts a command.
REQ-009 Port raddr, output, AW: registered read address driven to the RAM read port.
REQ-010 Port rdata, input, WIDTH: RAM read data, valid one clk after raddr.
REQ-011 Port out_data, output, WIDTH: stream data.
REQ-012 Port out_valid, output, 1: out_data is valid.
REQ-013 Port out_ready, input, 1: the sink accepts the word.
REQ-014 Port out_last, output, 1: the current word is the final word of the burst.
REQ-015 Port busy, output, 1: a burst is in progress.
REQ-016 Port done, output, 1: one-cycle pulse at burst completion.

Function
REQ-017 The block is an FSM with states IDLE, ISSUE and DRAIN.
REQ-018 cmd_ready = (state == IDLE); a command is accepted when cmd_valid && cmd_ready at a clk edge.
REQ-019 Acceptance with cmd_len > 0 transitions to ISSUE; acceptance with cmd_len = 0 stays in IDLE, issues no reads and pulses done in the next cycle.
REQ-020 In ISSUE, one read is issued per cycle while (buffer occupancy + reads in flight) < 4; raddr advances by 1 per issued read.
REQ-021 Address wrap: after ENTRIES-1, the next raddr is 0.
REQ-022 ISSUE transitions to DRAIN after cmd_len reads have been issued.
REQ-023 DRAIN transitions to IDLE on the handshake of the word flagged out_last.
REQ-024 Read data is captured into a 4-entry output FIFO exactly two cycles after its raddr was issued; no word is dropped or duplicated.
REQ-025 Latency: for acceptance in cycle C0, raddr = cmd_addr in C1 and the first out_valid occurs in C3.
REQ-026 With out_ready held at 1, throughput is one word per cycle and there are no bubbles inside a burst.
REQ-027 Handshake: a word transfers when out_valid && out_ready; while out_valid && !out_ready, out_data and out_last hold stable and out_valid stays 1.
REQ-028 out_last = 1 only on the cmd_len-th word.
REQ-029 busy = (state != IDLE).
REQ-030 done pulses in the cycle after the last handshake, coincident with cmd_ready returning to 1.
REQ-031 Overlapping writes to addresses not yet read are returned as whatever the RAM presents; the block does not check coherency.

Reset
REQ-032 While rst_n = 0, the block forces: state = IDLE, raddr = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0, done = 0, FIFO empty, in-flight count 0, and cmd_ready = 1.
REQ-033 Reset asserted mid-burst abandons the burst immediately; the first command after release behaves as in REQ-025.

Structure
REQ-034 Package ram_stream_reader_pkg holds the FSM state encoding (IDLE, ISSUE, DRAIN) and the constant FIFO_DEPTH = 4.
REQ-035 One sub-module, stream_out_fifo (a 4-entry, WIDTH+1-bit synchronous FIFO carrying data and last), implements the output buffer; the FSM and the read-issue counters live in the top module.

Verification
REQ-036 Bench RAM model: 1-cycle read latency, preloaded with mem[i] = 0x10 + i, ENTRIES = 8.
REQ-037 Scenario 1: cmd addr = 2, len = 3, out_ready = 1 -> out 0x12, 0x13, 0x14 in C3..C5; last on 0x14; done in C6.
REQ-038 Scenario 2: addr = 6, len = 4 -> out 0x16, 0x17, 0x10, 0x11 (raddr wraps 7 -> 0).
REQ-039 Scenario 3: addr = 0, len = 8 with out_ready pattern 1,0,0,1,0,1... -> exactly 0x10..0x17 in order; data stable while stalled; at most 4 buffered words.
REQ-040 Scenario 4: len = 0 -> no out_valid; done pulses in C1; cmd_ready stays 1.
REQ-041 Scenario 5: rst_n pulsed low after the 2nd word of a len = 8 burst -> out_valid = 0 and cmd_ready = 1 during reset; next cmd addr = 5, len = 2 -> 0x15, 0x16.
REQ-042 Scenario 6: back-to-back commands (cmd_valid held) len = 2 at addr = 0, then len = 1 at addr = 3 -> 0x10, 0x11(last), 0x13(last); second command accepted in the done cycle.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared state encoding and buffer constants for the RAM stream reader
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Output buffer depth; also the cap on buffered words plus reads in flight.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW    = FIFO_PW + 1;

endpackage

// File: rtl/stream_out_fifo.sv
// rtl/stream_out_fifo.sv - 4-entry synchronous FIFO carrying {last, data} for the output stream
module stream_out_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_s_tvalid,
    input  logic [WIDTH:0]     i_s_tdata,
    output logic               o_m_tvalid,
    output logic [WIDTH:0]     o_m_tdata,
    input  logic               i_m_tready,
    output logic [FIFO_CW-1:0] o_count
);

    logic [WIDTH:0]       r_mem [FIFO_DEPTH];
    logic [FIFO_PW-1:0]   r_wr_ptr;
    logic [FIFO_PW-1:0]   r_rd_ptr;
    logic [FIFO_CW-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_m_tvalid = (r_count != '0);
    assign w_pop      = o_m_tvalid & i_m_tready;
    // The producer never over-commits, but a full buffer still refuses a push without a pop.
    assign w_push     = i_s_tvalid & ((r_count < FIFO_CW'(FIFO_DEPTH)) | w_pop);
    // Head is masked while empty so data and last read as zero between bursts.
    assign o_m_tdata  = o_m_tvalid ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

    // Storage array: contents are only observed through the masked head, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_s_tdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CW'(1);
                2'b01:   r_count <= r_count - FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader turning RAM reads into a ready/valid stream with last and done
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  ENTRIES = 8,
    localparam int AW      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [AW:0]      cmd_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);

    state_t               r_state;
    logic [AW-1:0]        r_raddr;
    logic [AW:0]          r_left;
    logic                 r_v1;
    logic                 r_l1;
    logic                 r_v2;
    logic                 r_l2;
    logic                 r_done;

    logic                 w_accept;
    logic [AW-1:0]        w_next_addr;
    logic [FIFO_CW:0]     w_occ;
    logic                 w_can_issue;
    logic                 w_fifo_valid;
    logic [WIDTH:0]       w_fifo_data;
    logic [FIFO_CW-1:0]   w_fifo_count;
    logic                 w_pop;
    logic                 w_last_pop;

    assign w_accept    = cmd_valid & (r_state == ST_IDLE);
    assign w_next_addr = (r_raddr == LAST_ADDR) ? '0 : r_raddr + ADDR_ONE;
    // r_v1: raddr presented this cycle; r_v2: rdata for it on the bus this cycle.
    assign w_occ       = {1'b0, w_fifo_count} + {{FIFO_CW{1'b0}}, r_v1} + {{FIFO_CW{1'b0}}, r_v2};
    assign w_can_issue = (w_occ < (FIFO_CW + 1)'(FIFO_DEPTH));
    assign w_pop       = w_fifo_valid & out_ready;
    assign w_last_pop  = w_pop & w_fifo_data[WIDTH];

    // Command acceptance, read issue and burst sequencing. The first read goes out
    // on the accepting edge so raddr equals cmd_addr in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_raddr <= '0;
            r_left  <= '0;
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_raddr <= cmd_addr;
                            r_v1    <= 1'b1;
                            r_left  <= cmd_len - LEN_ONE;
                            if (cmd_len == LEN_ONE) begin
                                r_l1    <= 1'b1;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_can_issue) begin
                        r_raddr <= w_next_addr;
                        r_v1    <= 1'b1;
                        r_left  <= r_left - LEN_ONE;
                        if (r_left == LEN_ONE) begin
                            r_l1    <= 1'b1;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Delay the valid/last tags one more cycle to line up with the RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            r_l2 <= r_l1;
        end
    end

    stream_out_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_tvalid (r_v2),
        .i_s_tdata  ({r_l2, rdata}),
        .o_m_tvalid (w_fifo_valid),
        .o_m_tdata  (w_fifo_data),
        .i_m_tready (out_ready),
        .o_count    (w_fifo_count)
    );

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign raddr     = r_raddr;
    assign out_valid = w_fifo_valid;
    assign out_data  = w_fifo_data[WIDTH-1:0];
    assign out_last  = w_fifo_data[WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] raddr;
    logic [7:0] rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    ram_stream_reader #(.WIDTH(8), .ENTRIES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .raddr(raddr), .rdata(rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [8];
    always @(posedge clk) rdata <= mem[raddr];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] obs_d [16];
    logic       obs_l [16];
    int         obs_c [16];
    int         n_obs, done_cyc, stable_err, occ_err, valid_seen, ready_low, timeout;
    logic [2:0] raddr_c1;
    logic       busy_c1, ready_at_done;
    bit         pat [6];

    // Drives one command from the current negedge and records handshakes by cycle number (C0 = command cycle).
    task automatic run_cmd(input int addr, input int len, input int mode, input int stop_words);
        bit         pv, rdy;
        logic [7:0] pd;
        logic       pl;
        int         pops;
        n_obs = 0; done_cyc = -1; stable_err = 0; occ_err = 0; valid_seen = 0;
        ready_low = 0; timeout = 0; pv = 0; pd = '0; pl = 0; pops = 0;
        for (int i = 0; i < 16; i++) begin obs_d[i] = 'x; obs_l[i] = 1'bx; obs_c[i] = -1; end
        cmd_addr = 3'(addr); cmd_len = 4'(len); cmd_valid = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 1) begin raddr_c1 = raddr; busy_c1 = busy; end
            if (pv && !(out_valid === 1'b1 && out_data === pd && out_last === pl)) stable_err++;
            if (mode == 1 && (int'(raddr) + 1 - pops) > 4) occ_err++;
            if (cmd_ready !== 1'b1) ready_low++;
            if (out_valid === 1'b1) valid_seen++;
            rdy = (mode == 0) ? 1'b1 : pat[k % 6];
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                obs_d[n_obs] = out_data; obs_l[n_obs] = out_last; obs_c[n_obs] = k;
                n_obs++; pops++;
            end
            pv = (out_valid === 1'b1) && !rdy; pd = out_data; pl = out_last;
            if (done === 1'b1) begin done_cyc = k; ready_at_done = cmd_ready; break; end
            if (stop_words > 0 && n_obs >= stop_words) break;
        end
        if (done_cyc < 0 && stop_words == 0) timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", out_last); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        vectors++; if (raddr !== 3'd0) begin miscompares++; $display("FAIL reset_raddr got %0d want 0", raddr); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d = '{8'h12, 8'h13, 8'h14};
        run_cmd(2, 3, 0, 0);
        vectors++; if (raddr_c1 !== 3'd2) begin miscompares++; $display("FAIL basic_raddr_c1 got %0d want 2", raddr_c1); end
        vectors++; if (busy_c1 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_c1 got %b want 1", busy_c1); end
        vectors++; if (n_obs != 3) begin miscompares++; $display("FAIL basic_count got %0d want 3", n_obs); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 2) || obs_c[i] != 3 + i) begin
                miscompares++;
                $display("FAIL basic_word%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                         i, obs_d[i], obs_l[i], obs_c[i], exp_d[i], (i == 2), 3 + i);
            end
        end
        vectors++; if (done_cyc != 6 || ready_at_done !== 1'b1) begin miscompares++; $display("FAIL basic_done got cyc %0d ready %b want cyc 6 ready 1", done_cyc, ready_at_done); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [4];
        exp_d = '{8'h16, 8'h17, 8'h10, 8'h11};
        run_cmd(6, 4, 0, 0);
        vectors++; if (n_obs != 4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", n_obs); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 3) || obs_c[i] != 3 + i) begin
                miscompares++;
                $display("FAIL wrap_word%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                         i, obs_d[i], obs_l[i], obs_c[i], exp_d[i], (i == 3), 3 + i);
            end
        end
        vectors++; if (done_cyc != 7) begin miscompares++; $display("FAIL wrap_done got cyc %0d want 7", done_cyc); end
    endtask

    task automatic test_backpressure();
        run_cmd(0, 8, 1, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL bp_timeout got no done want done"); end
        vectors++; if (n_obs != 8) begin miscompares++; $display("FAIL bp_count got %0d want 8", n_obs); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs_d[i] !== 8'(8'h10 + i) || obs_l[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL bp_word%0d got %h last %b want %h last %b", i, obs_d[i], obs_l[i], 8'(8'h10 + i), (i == 7));
            end
        end
        vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL bp_stable got %0d unstable stalls want 0", stable_err); end
        vectors++; if (occ_err != 0) begin miscompares++; $display("FAIL bp_occupancy got %0d overruns want 0", occ_err); end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        run_cmd(3, 0, 0, 0);
        vectors++; if (valid_seen != 0) begin miscompares++; $display("FAIL zero_valid got %0d cycles want 0", valid_seen); end
        vectors++; if (done_cyc != 1) begin miscompares++; $display("FAIL zero_done got cyc %0d want 1", done_cyc); end
        vectors++; if (ready_low != 0) begin miscompares++; $display("FAIL zero_cmd_ready got %0d low cycles want 0", ready_low); end
    endtask

    task automatic test_reset_mid_burst();
        run_cmd(0, 8, 0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_outputs got valid %b ready %b want 0 1", out_valid, cmd_ready); end
        vectors++; if (busy !== 1'b0 || raddr !== 3'd0) begin miscompares++; $display("FAIL midrst_state got busy %b raddr %0d want 0 0", busy, raddr); end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(5, 2, 0, 0);
        vectors++; if (n_obs != 2) begin miscompares++; $display("FAIL midrst_count got %0d want 2", n_obs); end
        vectors++; if (obs_d[0] !== 8'h15 || obs_c[0] != 3 || obs_l[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_word0 got %h cyc %0d last %b want 15 cyc 3 last 0", obs_d[0], obs_c[0], obs_l[0]); end
        vectors++; if (obs_d[1] !== 8'h16 || obs_l[1] !== 1'b1) begin miscompares++; $display("FAIL midrst_word1 got %h last %b want 16 last 1", obs_d[1], obs_l[1]); end
    endtask

    task automatic test_back_to_back();
        int done1, done2, n;
        logic rd1;
        logic [7:0] exp_d [3];
        int exp_c [3];
        logic exp_l [3];
        exp_d = '{8'h10, 8'h11, 8'h13}; exp_c = '{3, 4, 8}; exp_l = '{1'b0, 1'b1, 1'b1};
        done1 = -1; done2 = -1; n = 0; rd1 = 1'b0;
        for (int i = 0; i < 16; i++) begin obs_d[i] = 'x; obs_l[i] = 1'bx; obs_c[i] = -1; end
        cmd_addr = 3'd0; cmd_len = 4'd2; cmd_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin cmd_addr = 3'd3; cmd_len = 4'd1; end
            if (done1 >= 0) cmd_valid = 1'b0;
            if (out_valid === 1'b1) begin obs_d[n] = out_data; obs_l[n] = out_last; obs_c[n] = k; n++; end
            if (done === 1'b1) begin
                if (done1 < 0) begin done1 = k; rd1 = cmd_ready; end
                else begin done2 = k; break; end
            end
        end
        cmd_valid = 1'b0;
        vectors++; if (n != 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_c[i] != exp_c[i]) begin
                miscompares++;
                $display("FAIL b2b_word%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                         i, obs_d[i], obs_l[i], obs_c[i], exp_d[i], exp_l[i], exp_c[i]);
            end
        end
        vectors++; if (done1 != 5 || rd1 !== 1'b1) begin miscompares++; $display("FAIL b2b_done1 got cyc %0d ready %b want cyc 5 ready 1", done1, rd1); end
        vectors++; if (done2 != 9) begin miscompares++; $display("FAIL b2b_done2 got cyc %0d want 9", done2); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
